// File: rtl/legv8_control_unit.sv
// Multi-cycle LEGv8 sequencer: latches an instruction in FETCH, decodes it in EXEC
// (plus a MEM cycle for LDUR) into the datapath control word and constant K.
module legv8_control_unit #(
    parameter logic [4:0] XZR = 5'd31
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [3:0]  alu_status,
    input  logic [3:0]  flags,
    output logic [28:0] controlWord,
    output logic [63:0] K,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_OR  = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01010;
    localparam logic [4:0] FS_XOR = 5'b01100;
    localparam logic [4:0] FS_LSL = 5'b10000;
    localparam logic [4:0] FS_LSR = 5'b10100;

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        idle_s;
    logic [1:0]  ps_s, seld_s;
    logic [4:0]  da_s, sa_s, sb_s, fs_s;
    logic        regw_s, ramw_s, selb_s, pcsel_s, sl_s;
    logic [63:0] k_s;
    logic        unused_alu_s;

    // Arithmetic ops (IR[24]=1) pick ADD/SUB from IR[30]; logical ops use IR[30:29].
    function automatic logic [4:0] alu_fs(input logic arith, input logic [1:0] op);
        if (arith) begin
            alu_fs = op[1] ? FS_SUB : FS_ADD;
        end else begin
            case (op)
                2'b00:   alu_fs = FS_AND;
                2'b01:   alu_fs = FS_OR;
                2'b10:   alu_fs = FS_XOR;
                default: alu_fs = FS_AND;
            endcase
        end
    endfunction

    function automatic logic cond_taken(input logic [3:0] cond, input logic [3:0] f);
        logic v, c, n, z;
        {v, c, n, z} = f;
        case (cond)
            4'd0:    cond_taken = z;
            4'd1:    cond_taken = !z;
            4'd2:    cond_taken = c;
            4'd3:    cond_taken = !c;
            4'd4:    cond_taken = n;
            4'd5:    cond_taken = !n;
            4'd6:    cond_taken = v;
            4'd7:    cond_taken = !v;
            4'd8:    cond_taken = c && !z;
            4'd9:    cond_taken = !c || z;
            4'd10:   cond_taken = (n == v);
            4'd11:   cond_taken = (n != v);
            4'd12:   cond_taken = !z && (n == v);
            4'd13:   cond_taken = z || (n != v);
            default: cond_taken = 1'b1;
        endcase
    endfunction

    // State and instruction register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            ir_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state and control-word decode from the latched instruction.
    always_comb begin
        ir_d    = ir_q;
        state_d = state_q;
        idle_s  = 1'b1;
        ps_s    = 2'b00;
        da_s    = XZR;
        sa_s    = XZR;
        sb_s    = XZR;
        fs_s    = FS_AND;
        regw_s  = 1'b0;
        ramw_s  = 1'b0;
        seld_s  = 2'b00;
        selb_s  = 1'b0;
        pcsel_s = 1'b0;
        sl_s    = 1'b0;
        k_s     = 64'd0;
        case (state_q)
            ST_FETCH: begin
                ir_d    = instruction;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                idle_s  = 1'b0;
                state_d = ST_FETCH;
                casez (ir_q[31:21])
                    11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
                    11'b11001010000, 11'b10101011000, 11'b11101011000: begin
                        da_s   = ir_q[4:0];
                        sa_s   = ir_q[9:5];
                        sb_s   = ir_q[20:16];
                        fs_s   = alu_fs(ir_q[24], ir_q[30:29]);
                        sl_s   = ir_q[24] & ir_q[29];
                        seld_s = 2'b01;
                        regw_s = 1'b1;
                        ps_s   = 2'b01;
                    end
                    11'b1101001101?: begin
                        da_s   = ir_q[4:0];
                        sa_s   = ir_q[9:5];
                        k_s    = {58'd0, ir_q[15:10]};
                        selb_s = 1'b1;
                        fs_s   = ir_q[21] ? FS_LSL : FS_LSR;
                        seld_s = 2'b01;
                        regw_s = 1'b1;
                        ps_s   = 2'b01;
                    end
                    11'b1001000100?, 11'b1101000100?, 11'b1001001000?,
                    11'b1011001000?, 11'b1101001000?: begin
                        da_s   = ir_q[4:0];
                        sa_s   = ir_q[9:5];
                        k_s    = {52'd0, ir_q[21:10]};
                        selb_s = 1'b1;
                        fs_s   = alu_fs(ir_q[24], ir_q[30:29]);
                        seld_s = 2'b01;
                        regw_s = 1'b1;
                        ps_s   = 2'b01;
                    end
                    11'b11111000000: begin
                        sa_s   = ir_q[9:5];
                        sb_s   = ir_q[4:0];
                        k_s    = {{55{ir_q[20]}}, ir_q[20:12]};
                        fs_s   = FS_ADD;
                        selb_s = 1'b1;
                        ramw_s = 1'b1;
                        ps_s   = 2'b01;
                    end
                    11'b11111000010: begin
                        sa_s    = ir_q[9:5];
                        k_s     = {{55{ir_q[20]}}, ir_q[20:12]};
                        fs_s    = FS_ADD;
                        selb_s  = 1'b1;
                        state_d = ST_MEM;
                    end
                    11'b000101?????, 11'b100101?????: begin
                        k_s     = {{38{ir_q[25]}}, ir_q[25:0]};
                        pcsel_s = 1'b1;
                        ps_s    = 2'b10;
                        if (ir_q[31]) begin
                            da_s   = 5'd30;
                            seld_s = 2'b11;
                            regw_s = 1'b1;
                        end else begin
                            da_s   = XZR;
                        end
                    end
                    11'b11010110000: begin
                        sa_s = ir_q[9:5];
                        ps_s = 2'b11;
                    end
                    // IR[24] separates CBNZ from CBZ, so it flips the sense of Z.
                    11'b1011010????: begin
                        sb_s    = ir_q[4:0];
                        fs_s    = FS_OR;
                        k_s     = {{45{ir_q[23]}}, ir_q[23:5]};
                        pcsel_s = 1'b1;
                        ps_s    = (alu_status[0] ^ ir_q[24]) ? 2'b10 : 2'b01;
                    end
                    11'b01010100???: begin
                        k_s     = {{45{ir_q[23]}}, ir_q[23:5]};
                        pcsel_s = 1'b1;
                        ps_s    = cond_taken(ir_q[3:0], flags) ? 2'b10 : 2'b01;
                    end
                    default: begin
                        idle_s  = 1'b1;
                        state_d = ST_HALT;
                    end
                endcase
            end
            ST_MEM: begin
                idle_s  = 1'b0;
                da_s    = ir_q[4:0];
                sa_s    = ir_q[9:5];
                k_s     = {{55{ir_q[20]}}, ir_q[20:12]};
                fs_s    = FS_ADD;
                selb_s  = 1'b1;
                regw_s  = 1'b1;
                ps_s    = 2'b01;
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    assign controlWord = idle_s ? 29'd0 :
        {ps_s, da_s, sa_s, sb_s, fs_s, regw_s, ramw_s, seld_s, selb_s, pcsel_s, sl_s};
    assign K            = idle_s ? 64'd0 : k_s;
    assign halted       = (state_q == ST_HALT);
    assign unused_alu_s = ^alu_status[3:1];

endmodule
